// File: rtl/acc_recv_mem_writer_if.sv
// rtl/acc_recv_mem_writer_if.sv - Avalon-MM write-master bus bundle
//
// Groups the Avalon-MM write signals driven by acc_recv_mem_writer.
//   master modport : drives address/write/writedata/byteenable, samples waitrequest
//   slave modport  : samples the write signals, drives waitrequest
interface acc_recv_mem_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   avm_address;
  logic                    avm_write;
  logic [DATA_WIDTH-1:0]   avm_writedata;
  logic [DATA_WIDTH/8-1:0] avm_byteenable;
  logic                    avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest
  );
endinterface

// File: rtl/acc_recv_mem_writer.sv
// rtl/acc_recv_mem_writer.sv - receive-engine write buffer replaying to Avalon-MM
//
// Buffers single-cycle write pulses from the receive matcher in a small FIFO
// and replays them, in order, as Avalon-MM writes with waitrequest handling.
// The matcher cannot be stalled, so writes arriving to a full FIFO are dropped
// and counted.
//   nios_clk, reset          : clock, asynchronous active-high reset
//   in_write/in_addr/in_data : one-cycle write request from the matcher
//   clear_stats              : synchronous clear of drop_count/overflow/writes_done
//   avm (master)             : Avalon-MM write master toward main memory
//   fifo_level               : FIFO occupancy, not counting the output stage
//   drop_count, overflow     : saturating drop counter, sticky drop flag
//   writes_done              : completed Avalon writes (wraps)
//   idle                     : nothing buffered, nothing in flight, no input
module acc_recv_mem_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_AW    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  nios_clk,
  input  logic                  reset,
  input  logic                  in_write,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  clear_stats,
  acc_recv_mem_writer_if.master avm,
  output logic [FIFO_AW:0]      fifo_level,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  overflow,
  output logic [31:0]           writes_done,
  output logic                  idle
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int LSB      = $clog2(BE_WIDTH);
  // Clears the byte-offset bits so every Avalon address is word aligned.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1));
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(1) << FIFO_AW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t fifo_mem [2**FIFO_AW];

  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           writes_done_q, writes_done_d;

  logic accept, pop, push, drop;

  always_comb begin
    accept = (state_q == ST_BUSY) && !avm.avm_waitrequest;
    // The output stage is reloaded whenever it is empty or being retired,
    // which gives back-to-back writes at one per cycle.
    pop    = (count_q != '0) && ((state_q == ST_IDLE) || accept);
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    push   = in_write && ((count_q != DEPTH) || pop);
    drop   = in_write && !push;

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop) begin
      state_d = ST_BUSY;
      addr_d  = fifo_mem[rd_ptr_q].addr & ADDR_MASK;
      data_d  = fifo_mem[rd_ptr_q].data;
    end else if (accept) begin
      state_d = ST_IDLE;
    end

    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    writes_done_d = writes_done_q;
    if (clear_stats) begin
      drop_count_d  = '0;
      overflow_d    = 1'b0;
      writes_done_d = '0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end
      if (accept) writes_done_d = writes_done_q + 32'd1;
    end
  end

  always_ff @(posedge nios_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
      writes_done_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
      writes_done_q <= writes_done_d;
    end
  end

  // Storage array needs no reset: only entries covered by count_q are read.
  always_ff @(posedge nios_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: in_addr, data: in_data};
  end

  assign avm.avm_write      = (state_q == ST_BUSY);
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = data_q;
  assign avm.avm_byteenable = {BE_WIDTH{state_q == ST_BUSY}};

  assign fifo_level  = count_q;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;
  assign writes_done = writes_done_q;
  assign idle        = (count_q == '0) && (state_q == ST_IDLE) && !in_write;
endmodule

// File: tb/tb_acc_recv_mem_writer.sv
// tb/tb_acc_recv_mem_writer.sv - directed self-checking bench for acc_recv_mem_writer
module tb_acc_recv_mem_writer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic        nios_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_write = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        clear_stats = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;
  logic        overflow;
  logic [31:0] writes_done;
  logic        idle;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 nios_clk = ~nios_clk;

  acc_recv_mem_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) avm ();

  acc_recv_mem_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_AW(3), .CNT_WIDTH(16)
  ) dut (
    .nios_clk   (nios_clk),
    .reset      (reset),
    .in_write   (in_write),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .clear_stats(clear_stats),
    .avm        (avm),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .overflow   (overflow),
    .writes_done(writes_done),
    .idle       (idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge nios_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_write = 1'b0;
    clear_stats = 1'b0;
    avm.avm_waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    in_write = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_write = 1'b0;
  endtask

  initial begin
    avm.avm_waitrequest = 1'b0;
    tick();
    tick();
    // Reset values
    chk("rst_write", avm.avm_write, 0);
    chk("rst_addr", avm.avm_address, 0);
    chk("rst_data", avm.avm_writedata, 0);
    chk("rst_be", avm.avm_byteenable, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", writes_done, 0);
    chk("rst_idle", idle, 1);
    reset = 1'b0;

    // Single write: avm_write two cycles after the request
    push(32'h1000, 32'hCAFEF00D);
    chk("sw_n1_write", avm.avm_write, 0);
    chk("sw_n1_level", fifo_level, 1);
    chk("sw_n1_idle", idle, 0);
    tick();
    chk("sw_write", avm.avm_write, 1);
    chk("sw_addr", avm.avm_address, 32'h1000);
    chk("sw_data", avm.avm_writedata, 32'hCAFEF00D);
    chk("sw_be", avm.avm_byteenable, 4'hF);
    chk("sw_level", fifo_level, 0);
    tick();
    chk("sw_done_write", avm.avm_write, 0);
    chk("sw_done_be", avm.avm_byteenable, 0);
    chk("sw_done_cnt", writes_done, 1);
    chk("sw_done_idle", idle, 1);
    // Unaligned byte address is word aligned on the bus
    push(32'h2007, 32'h12345678);
    tick();
    chk("align_addr", avm.avm_address, 32'h2004);
    tick();
    chk("align_done", writes_done, 2);

    // Stall hold
    do_reset();
    avm.avm_waitrequest = 1'b1;
    push(32'h10, 32'h1);
    push(32'h14, 32'h2);
    push(32'h18, 32'h3);
    for (int i = 0; i < 4; i++) begin
      chk("stall_write", avm.avm_write, 1);
      chk("stall_addr", avm.avm_address, 32'h10);
      chk("stall_level", fifo_level, 2);
      tick();
    end
    avm.avm_waitrequest = 1'b0;
    chk("stall_rel_addr0", avm.avm_address, 32'h10);
    tick();
    chk("stall_rel_addr1", avm.avm_address, 32'h14);
    chk("stall_rel_write1", avm.avm_write, 1);
    tick();
    chk("stall_rel_addr2", avm.avm_address, 32'h18);
    chk("stall_rel_write2", avm.avm_write, 1);
    tick();
    chk("stall_end_write", avm.avm_write, 0);
    chk("stall_end_done", writes_done, 3);
    chk("stall_end_idle", idle, 1);

    // Overflow: 1 in output stage, 8 buffered, 3 dropped
    do_reset();
    avm.avm_waitrequest = 1'b1;
    for (int i = 0; i < 12; i++) push(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    chk("ovf_level", fifo_level, 8);
    chk("ovf_drop", drop_count, 3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_addr", avm.avm_address, 32'h100);
    avm.avm_waitrequest = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("ovf_drain_write", avm.avm_write, 1);
      chk("ovf_drain_addr", avm.avm_address, 32'h100 + 32'(4 * i));
      chk("ovf_drain_data", avm.avm_writedata, 32'hA0 + 32'(i));
      tick();
    end
    chk("ovf_end_write", avm.avm_write, 0);
    chk("ovf_end_done", writes_done, 9);
    chk("ovf_end_level", fifo_level, 0);
    chk("ovf_end_drop", drop_count, 3);

    // Full with pop: push accepted when an accept frees a slot
    do_reset();
    avm.avm_waitrequest = 1'b1;
    for (int i = 0; i < 9; i++) push(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
    chk("full_level", fifo_level, 8);
    chk("full_drop", drop_count, 0);
    avm.avm_waitrequest = 1'b0;
    push(32'h300, 32'hC0);
    avm.avm_waitrequest = 1'b1;
    chk("fpop_level", fifo_level, 8);
    chk("fpop_drop", drop_count, 0);
    chk("fpop_ovf", overflow, 0);
    chk("fpop_done", writes_done, 1);
    chk("fpop_addr", avm.avm_address, 32'h204);

    // clear_stats priority over drop and over accept
    push(32'h400, 32'hD0);
    chk("drop1_cnt", drop_count, 1);
    chk("drop1_ovf", overflow, 1);
    clear_stats = 1'b1;
    push(32'h404, 32'hD1);
    clear_stats = 1'b0;
    chk("clr_drop_cnt", drop_count, 0);
    chk("clr_drop_ovf", overflow, 0);
    chk("clr_drop_done", writes_done, 0);
    avm.avm_waitrequest = 1'b0;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    avm.avm_waitrequest = 1'b1;
    chk("clr_acc_done", writes_done, 0);
    chk("clr_acc_addr", avm.avm_address, 32'h208);
    avm.avm_waitrequest = 1'b0;
    tick();
    avm.avm_waitrequest = 1'b1;
    chk("post_clr_done", writes_done, 1);
    chk("post_clr_addr", avm.avm_address, 32'h20C);

    // Reset mid-write, observed before the next edge
    chk("pre_rst_write", avm.avm_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_write", avm.avm_write, 0);
    chk("mid_rst_addr", avm.avm_address, 0);
    chk("mid_rst_be", avm.avm_byteenable, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_done", writes_done, 0);
    tick();
    reset = 1'b0;
    avm.avm_waitrequest = 1'b0;
    tick();
    chk("post_rst_idle", idle, 1);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_nowrite", avm.avm_write, 0);
      tick();
    end
    chk("post_rst_done", writes_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/acc_recv_mem_writer.md
# acc_recv_mem_writer

Downstream stage of the accelerated receive engine. It accepts single-cycle write pulses (write, write_addr, data_to_mem) that the matcher emits when an eager packet hits a posted receive, and buffers them in a small FIFO. It replays them as Avalon-MM master writes toward main memory with full waitrequest handling. The matcher has no backpressure, so this block absorbs bursts, and it counts and flags any writes it must drop.

## Interface
- DATA_WIDTH, 32, write data width (multiple of 8)
- ADDR_WIDTH, 32, byte address width
- FIFO_AW, 3, log2 of FIFO depth (depth 8)
- CNT_WIDTH, 16, width of drop counter
- nios_clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_write  in  1  one-cycle write request from receive engine
- in_addr  in  ADDR_WIDTH  target byte address
- in_data  in  DATA_WIDTH  payload word
- clear_stats  in  1  synchronous clear of statistics
- avm_address  out  ADDR_WIDTH  Avalon address, low log2(DATA_WIDTH/8) bits forced 0
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  DATA_WIDTH  Avalon write data
- avm_byteenable  out  DATA_WIDTH/8  all ones while avm_write is high, else 0
- avm_waitrequest  in  1  slave stall
- fifo_level  out  FIFO_AW+1  entries in FIFO, excluding the output stage
- drop_count  out  CNT_WIDTH  dropped requests, saturating
- overflow  out  1  sticky; set on first drop
- writes_done  out  32  completed Avalon writes, wraps
- idle  out  1  FIFO empty, output stage empty, in_write low

## Operation
- FIFO: 2^FIFO_AW entries of {addr, data}, circular read/write pointers, separate occupancy count.
- Push: on in_write. Accepted if count < depth, or if a pop occurs in the same cycle.
- Drop: on in_write when full with no pop in the same cycle.
  - Entry is discarded.
  - drop_count increments and saturates at 2^CNT_WIDTH-1.
  - overflow is set.
- Output stage: one register set {avm_address, avm_writedata} plus a valid bit that drives avm_write.
- FSM states:
  - IDLE: avm_write=0. When FIFO is non-empty, pop the head into the output stage and go to BUSY.
  - BUSY: avm_write=1, address and data held stable while avm_waitrequest=1.
    - On avm_waitrequest=0 (accept): writes_done+1.
    - If FIFO is non-empty, pop the next head into the output stage in the same edge and stay in BUSY. This gives back-to-back writes at 1/cycle.
    - Otherwise go to IDLE.
- Ordering: strictly FIFO; no reordering and no merging of writes to the same address.
- clear_stats: clears drop_count, overflow, and writes_done; has priority over a same-cycle increment. Does not touch the FIFO or an in-flight write.
- Reset (asynchronous), any time, including mid-write:
  - Pointers, count, FSM (IDLE) and all statistics go to 0.
  - avm_write, avm_address, avm_writedata and avm_byteenable go to 0 immediately.
  - The in-flight transaction is abandoned.
  - idle=1 after the release edge.

## Timing
- Reset values: all outputs 0 except idle=1.
- Latency with the FIFO empty and waitrequest low:
  - in_write high in cycle N; entry written at the edge ending N.
  - Entry popped into the output stage at the edge ending N+1.
  - avm_write high in cycle N+2, accepted at that edge.
- Sustained throughput: one write per cycle while avm_waitrequest=0.
- Level timing: fifo_level reflects the count registered at the previous edge; simultaneous push and pop leaves it unchanged.
- Full boundary, fifo_level = depth:
  - in_write in a cycle where BUSY is accepted → accepted.
  - in_write in a cycle where avm_waitrequest=1 → dropped.
- Empty boundary: a push into an empty FIFO is not visible to the FSM until the next cycle; there is no bypass.
- writes_done wraps modulo 2^32.

## Test plan
- Single write: after reset, in_write with addr 0x1000, data 0xCAFEF00D → avm_write high exactly 2 cycles later with address 0x1000, data 0xCAFEF00D, byteenable 0xF; writes_done=1; idle returns to 1.
- Stall hold: 3 consecutive writes (addresses 0x10, 0x14, 0x18) with avm_waitrequest high for 5 cycles → avm_address stays 0x10 throughout the stall, then 0x10, 0x14, 0x18 complete on consecutive cycles; writes_done=3.
- Overflow: waitrequest held high, 12 in_write pulses at depth 8 → 1 write in the output stage, 8 in the FIFO, 3 dropped; drop_count=3 and overflow=1; release → exactly 9 writes in order.
- Full with pop: FIFO full, in_write in the same cycle as an Avalon accept → push accepted, drop_count unchanged, fifo_level stays 8.
- Reset mid-write: assert reset while avm_write=1 and waitrequest=1 → avm_write low before the next edge; fifo_level=0; writes_done=0; no stale write after release.
- clear_stats asserted in the same cycle as an accept and a drop → drop_count=0, overflow=0, writes_done=0 on the next cycle.
